// File: rtl/thresh_pkg.sv
// rtl/thresh_pkg.sv - shared constants and state encoding for the threshold comparator
package thresh_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PW    = 4;

  localparam logic [1:0] MODE_GT  = 2'b00;
  localparam logic [1:0] MODE_LT  = 2'b01;
  localparam logic [1:0] MODE_WIN = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_ARM    = 2'b01,
    ST_ON     = 2'b10,
    ST_DISARM = 2'b11
  } state_t;

  // The filtered level is high while latched on or while a release is pending
  function automatic logic state_level(input state_t s);
    return (s == ST_ON) || (s == ST_DISARM);
  endfunction

endpackage

// File: rtl/thresh_cmp_core.sv
// rtl/thresh_cmp_core.sv - combinational set/clear decode for one sample
module thresh_cmp_core
  import thresh_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] i_ref_hi,
  input  logic [WIDTH-1:0] i_ref_lo,
  input  logic [1:0]       i_mode,
  output logic             o_set,
  output logic             o_clear
);

  logic w_gt_hi;
  logic w_lt_lo;

  generate
    if (SIGNED != 0) begin : g_signed
      assign w_gt_hi = $signed(i_in) > $signed(i_ref_hi);
      assign w_lt_lo = $signed(i_in) < $signed(i_ref_lo);
    end else begin : g_unsigned
      assign w_gt_hi = i_in > i_ref_hi;
      assign w_lt_lo = i_in < i_ref_lo;
    end
  endgenerate

  // Between the thresholds GT/LT neither set nor clear, which forms the hysteresis band
  always_comb begin
    o_set   = 1'b0;
    o_clear = 1'b0;
    case (i_mode)
      MODE_GT: begin
        o_set   = w_gt_hi;
        o_clear = w_lt_lo;
      end
      MODE_LT: begin
        o_set   = w_lt_lo;
        o_clear = w_gt_hi;
      end
      MODE_WIN: begin
        o_set   = w_gt_hi | w_lt_lo;
        o_clear = ~(w_gt_hi | w_lt_lo);
      end
      default: begin
        o_set   = 1'b0;
        o_clear = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/thresh_cmp_hyst.sv
// rtl/thresh_cmp_hyst.sv - hysteresis comparator with persistence filter and sticky alarm
module thresh_cmp_hyst
  import thresh_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PW     = DEF_PW,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ref_hi,
  input  logic [WIDTH-1:0] ref_lo,
  input  logic [PW-1:0]    persist,
  input  logic             clr,
  output logic             raw,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic             alarm
);

  localparam logic [PW:0] ONE_W = (PW + 1)'(1);

  state_t        r_state;
  logic [PW-1:0] r_cnt;
  logic [1:0]    r_mode_q;
  logic          r_raw;
  logic          r_out;
  logic          r_rise;
  logic          r_fall;
  logic          r_alarm;

  logic          w_set;
  logic          w_clear;
  logic [PW-1:0] w_p;
  logic [PW:0]   w_cnt_ext;
  logic [PW-1:0] w_cnt_inc;
  logic          w_reach;
  state_t        w_state_n;
  logic [PW-1:0] w_cnt_n;
  logic          w_raw_n;
  logic          w_out_n;

  thresh_cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .i_in     (in),
    .i_ref_hi (ref_hi),
    .i_ref_lo (ref_lo),
    .i_mode   (mode),
    .o_set    (w_set),
    .o_clear  (w_clear)
  );

  // Persistence bookkeeping: effective P, saturating increment, and "this sample completes it"
  always_comb begin
    w_p       = (persist == '0) ? PW'(1) : persist;
    w_cnt_ext = {1'b0, r_cnt} + ONE_W;
    w_cnt_inc = w_cnt_ext[PW] ? r_cnt : w_cnt_ext[PW-1:0];
    w_reach   = w_cnt_ext >= {1'b0, w_p};
  end

  // Next-state decode; >= on the reach test lets a lowered persist finish on the next qualifying sample
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_raw_n   = r_raw;
    if (!en || (mode == MODE_OFF)) begin
      w_state_n = ST_OFF;
      w_cnt_n   = '0;
      w_raw_n   = 1'b0;
    end else if (mode != r_mode_q) begin
      w_state_n = ST_OFF;
      w_cnt_n   = '0;
    end else if (in_valid) begin
      w_raw_n = w_set;
      case (r_state)
        ST_OFF: begin
          if (w_set) begin
            w_state_n = w_reach ? ST_ON : ST_ARM;
            w_cnt_n   = w_reach ? '0 : w_cnt_inc;
          end
        end
        ST_ARM: begin
          if (w_set) begin
            w_state_n = w_reach ? ST_ON : ST_ARM;
            w_cnt_n   = w_reach ? '0 : w_cnt_inc;
          end else begin
            w_state_n = ST_OFF;
            w_cnt_n   = '0;
          end
        end
        ST_ON: begin
          if (w_clear) begin
            w_state_n = w_reach ? ST_OFF : ST_DISARM;
            w_cnt_n   = w_reach ? '0 : w_cnt_inc;
          end
        end
        ST_DISARM: begin
          if (w_clear) begin
            w_state_n = w_reach ? ST_OFF : ST_DISARM;
            w_cnt_n   = w_reach ? '0 : w_cnt_inc;
          end else begin
            w_state_n = ST_ON;
            w_cnt_n   = '0;
          end
        end
        default: begin
          w_state_n = ST_OFF;
          w_cnt_n   = '0;
        end
      endcase
    end
    w_out_n = state_level(w_state_n);
  end

  // Register state, level, edge pulses and the sticky alarm (a rise beats a coincident clr)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_mode_q <= MODE_GT;
      r_raw    <= 1'b0;
      r_out    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_alarm  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_mode_q <= mode;
      r_raw    <= w_raw_n;
      r_out    <= w_out_n;
      r_rise   <= w_out_n & ~r_out;
      r_fall   <= ~w_out_n & r_out;
      r_alarm  <= (r_alarm & ~clr) | (w_out_n & ~r_out);
    end
  end

  assign raw   = r_raw;
  assign out   = r_out;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign alarm = r_alarm;

endmodule

// File: tb/tb_thresh_cmp_hyst.sv
// tb/tb_thresh_cmp_hyst.sv - directed self-checking bench for thresh_cmp_hyst
module tb_thresh_cmp_hyst;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] din;
  logic        in_valid;
  logic [15:0] ref_hi;
  logic [15:0] ref_lo;
  logic [3:0]  persist;
  logic        clr;

  logic raw, out, rise, fall, alarm;
  logic raw_s, out_s, rise_s, fall_s, alarm_s;

  int n_checks;
  int n_errors;

  thresh_cmp_hyst #(.WIDTH(16), .PW(4), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din), .in_valid(in_valid),
    .ref_hi(ref_hi), .ref_lo(ref_lo), .persist(persist), .clr(clr),
    .raw(raw), .out(out), .rise(rise), .fall(fall), .alarm(alarm)
  );

  thresh_cmp_hyst #(.WIDTH(16), .PW(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din), .in_valid(in_valid),
    .ref_hi(ref_hi), .ref_lo(ref_lo), .persist(persist), .clr(clr),
    .raw(raw_s), .out(out_s), .rise(rise_s), .fall(fall_s), .alarm(alarm_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] v, input logic vld);
    din      = v;
    in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] brk [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b1; mode = 2'b00; din = '0; in_valid = 1'b0;
    ref_hi = 16'd1000; ref_lo = 16'd900; persist = 4'd3; clr = 1'b0;
    brk[0] = 16'd1001; brk[1] = 16'd1001; brk[2] = 16'd500; brk[3] = 16'd1001; brk[4] = 16'd1001;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_raw", raw, 0);
    check("rst_alarm", alarm, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    rst = 1'b0;

    // GT with persist 3
    step(16'd1001, 1); check("gt1_raw", raw, 1); check("gt1_out", out, 0);
    step(16'd1001, 1); check("gt2_out", out, 0);
    step(16'd1001, 1); check("gt3_out", out, 1); check("gt3_rise", rise, 1); check("gt3_alarm", alarm, 1);
    step(16'd0, 0);    check("gt_idle_out", out, 1); check("gt_idle_rise", rise, 0);
    for (int i = 0; i < 5; i++) begin
      step(16'd950, 1); check("band_out", out, 1);
    end
    check("band_raw", raw, 0);
    step(16'd899, 1); check("clr1_out", out, 1);
    step(16'd899, 1); check("clr2_out", out, 1); check("clr2_fall", fall, 0);
    step(16'd899, 1); check("clr3_out", out, 0); check("clr3_fall", fall, 1);
    step(16'd0, 0);   check("clr_idle_fall", fall, 0); check("alarm_kept", alarm, 1);
    clr = 1'b1;
    step(16'd0, 0);   check("alarm_clr", alarm, 0);
    clr = 1'b0;

    // Persistence break, then valid gaps that must not reset the count
    for (int i = 0; i < 5; i++) begin
      step(brk[i], 1); check("brk_out", out, 0);
    end
    step(16'd0, 0);
    step(16'd0, 0);
    step(16'd1001, 1); check("gap_out", out, 1); check("gap_rise", rise, 1);

    // Mode change while ON: forced off, sample not evaluated so raw holds
    mode = 2'b01;
    step(16'd1001, 1); check("mchg_out", out, 0); check("mchg_fall", fall, 1); check("mchg_raw", raw, 1);

    // WINDOW, persist 1
    mode = 2'b10; ref_lo = 16'd100; ref_hi = 16'd200; persist = 4'd1;
    step(16'd0, 0);   check("win_settle", out, 0);
    step(16'd150, 1); check("win150", out, 0); check("win150_raw", raw, 0);
    step(16'd201, 1); check("win201", out, 1);
    step(16'd99, 1);  check("win99", out, 1);
    step(16'd100, 1); check("win100", out, 0); check("win100_fall", fall, 1);

    // LT: -6 vs -5 orders the same both ways; -6 vs 5 only sets when signed
    mode = 2'b01; ref_lo = 16'hFFFB; ref_hi = 16'hFFFD;
    step(16'd0, 0);
    step(16'hFFFA, 1); check("lt_u_set", out, 1); check("lt_s_set", out_s, 1);
    step(16'hFFFE, 1); check("lt_u_clr", out, 0); check("lt_s_clr", out_s, 0);
    ref_lo = 16'd5; ref_hi = 16'd10;
    step(16'hFFFA, 1); check("lt_u_neg", out, 0); check("lt_s_neg", out_s, 1);

    // clr coincident with rise, persist 0 acts as 1
    mode = 2'b00; ref_hi = 16'd1000; ref_lo = 16'd900; persist = 4'd0; clr = 1'b1;
    step(16'd0, 0);    check("ctl_alarm0", alarm, 0);
    step(16'd1001, 1); check("p0_out", out, 1); check("p0_rise", rise, 1); check("clr_rise_alarm", alarm, 1);
    clr = 1'b0; en = 1'b0;
    step(16'd1001, 1); check("en0_out", out, 0); check("en0_fall", fall, 1); check("en0_raw", raw, 0);
    check("en0_alarm", alarm, 1);
    en = 1'b1;

    // persist lowered below the running count completes on the next sample
    persist = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step(16'd1001, 1); check("pd_arm_out", out, 0);
    end
    persist = 4'd2;
    step(16'd1001, 1); check("pd_out", out, 1); check("pd_rise", rise, 1);

    // Asynchronous reset mid-ON with alarm set
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", out, 0);
    check("arst_alarm", alarm, 0);
    check("arst_rise", rise, 0);
    check("arst_raw", raw, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(16'd0, 0); check("post_rst_out", out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
